// File: rtl/packed_lane_fifo.sv
// Packed multi-lane FIFO with per-lane invert on push and optional per-lane parity.
// Define PACKED_LANE_PARITY_EN to store and present per-lane even parity of each entry.
module packed_lane_fifo #(
    parameter int NCH   = 4,
    parameter int AW    = 4,
    parameter int VW    = 4,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NCH*(AW+VW)-1:0]      in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NCH-1:0]              lane_en,
    output logic [NCH*(AW+VW)-1:0]      out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      count,
    output logic [NCH-1:0]              par_out
);

    localparam int LW = AW + VW;
    localparam int DW = NCH * LW;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [DW-1:0] wdata;
    logic          push;
    logic          pop;

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Ternary rather than XOR so a Z in an untouched lane is stored as-is.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            wdata[i*LW +: LW] = lane_en[i] ? ~in_data[i*LW +: LW]
                                           : in_data[i*LW +: LW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_data = out_valid ? mem[rd_ptr] : '0;

`ifdef PACKED_LANE_PARITY_EN
    logic [NCH-1:0] par_mem [DEPTH];
    logic [NCH-1:0] wpar;

    always_comb begin
        wpar = '0;
        for (int i = 0; i < NCH; i++) begin
            wpar[i] = ^wdata[i*LW +: LW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            par_mem[wr_ptr] <= wpar;
        end
    end

    assign par_out = out_valid ? par_mem[rd_ptr] : '0;
`else
    assign par_out = '0;
`endif

endmodule
